lcd_msg_sequencer: RTL

//  Parametrised successor to the fixed-text LCD writer. Drives the LCD_Controller command

---
 rtl/lcd_msg_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lcd_msg_sequencer.sv
// Paints one of NUM_MSG 2x16 messages through the LCD_Controller start/done handshake.
// Runs the init commands once after reset, then one frame per message change or refresh request.
module lcd_msg_sequencer #(
  parameter int NUM_MSG    = 4,
  parameter int MSG_W      = 2,
  parameter int DLY_CYCLES = 262142
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [MSG_W-1:0] iMSG_SEL,
  input  logic             iREFRESH,
  output logic [MSG_W-1:0] oCHAR_MSG,
  output logic [4:0]       oCHAR_POS,
  input  logic [7:0]       iCHAR,
  output logic [7:0]       oCMD_DATA,
  output logic             oCMD_RS,
  output logic             oCMD_START,
  input  logic             iCMD_DONE,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_NEXT} state_t;

  localparam int           CNT_W       = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
  localparam logic [5:0]   FRAME_STEP  = 6'd4;
  localparam logic [5:0]   LAST_STEP   = 6'd37;
  localparam logic [MSG_W:0] NUM_MSG_L = (MSG_W+1)'(NUM_MSG);

  state_t             state_reg, state_next;
  logic [5:0]         step_reg;
  logic [MSG_W-1:0]   shown_msg_reg;
  logic               pending_reg;
  logic [1:0]         phase_reg;
  logic [7:0]         char_reg;
  logic [CNT_W-1:0]   dly_cnt_reg;
  logic [MSG_W-1:0]   char_msg_reg;
  logic [4:0]         char_pos_reg;
  logic [7:0]         cmd_data_reg;
  logic               cmd_rs_reg;
  logic               cmd_start_reg;
  logic               busy_reg;
  logic               frame_done_reg;

  logic [MSG_W-1:0]   sel_clamped;
  logic               trig;
  logic               repaint_due;
  logic               last_step;
  logic               dly_last;
  logic               start_frame;
  logic               step_is_char;
  logic [4:0]         step_pos;
  logic [7:0]         step_byte;

  assign sel_clamped = ({1'b0, iMSG_SEL} >= NUM_MSG_L) ? '0 : iMSG_SEL;
  assign trig        = (sel_clamped != shown_msg_reg) || iREFRESH;
  assign repaint_due = trig || pending_reg;
  assign last_step   = (step_reg == LAST_STEP);
  assign dly_last    = (dly_cnt_reg == CNT_W'(DLY_CYCLES - 1));
  // A new frame latches the selection whether it starts from idle or chains off the last one.
  assign start_frame = repaint_due &&
                       ((state_reg == S_IDLE) || ((state_reg == S_NEXT) && last_step));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_reg <= S_INIT;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (repaint_due) state_next = S_FETCH;
      S_INIT:  state_next = S_ISSUE;
      S_FETCH: if (!step_is_char || (phase_reg == 2'd2)) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (iCMD_DONE) state_next = (DLY_CYCLES == 0) ? S_NEXT : S_DELAY;
      S_DELAY: if (dly_last) state_next = S_NEXT;
      S_NEXT: begin
        if (last_step)               state_next = repaint_due ? S_FETCH : S_IDLE;
        else if (step_reg < 6'd3)    state_next = S_INIT;
        else                         state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Step 0..3 init, 4 line-1 address, 5..20 chars 0..15, 21 line-2 address, 22..37 chars 16..31.
  always_comb begin
    step_is_char = 1'b0;
    step_pos     = 5'd0;
    step_byte    = 8'h00;
    case (step_reg)
      6'd0:  step_byte = 8'h38;
      6'd1:  step_byte = 8'h0C;
      6'd2:  step_byte = 8'h01;
      6'd3:  step_byte = 8'h06;
      6'd4:  step_byte = 8'h80;
      6'd21: step_byte = 8'hC0;
      default: begin
        step_is_char = 1'b1;
        step_byte    = char_reg;
        step_pos     = (step_reg < 6'd21) ? 5'(step_reg - 6'd5) : 5'(step_reg - 6'd6);
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      step_reg       <= '0;
      shown_msg_reg  <= '0;
      pending_reg    <= 1'b0;
      phase_reg      <= '0;
      char_reg       <= '0;
      dly_cnt_reg    <= '0;
      char_msg_reg   <= '0;
      char_pos_reg   <= '0;
      cmd_data_reg   <= '0;
      cmd_rs_reg     <= 1'b0;
      cmd_start_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      busy_reg       <= (state_next != S_IDLE);
      if (start_frame) begin
        shown_msg_reg <= sel_clamped;
        pending_reg   <= 1'b0;
        step_reg      <= FRAME_STEP;
      end else if ((state_reg != S_IDLE) && trig) begin
        pending_reg   <= 1'b1;
      end
      case (state_reg)
        S_FETCH: begin
          if (step_is_char) begin
            case (phase_reg)
              2'd0: begin
                char_msg_reg <= shown_msg_reg;
                char_pos_reg <= step_pos;
                phase_reg    <= 2'd1;
              end
              2'd1:    phase_reg <= 2'd2;
              default: begin
                char_reg  <= iCHAR;
                phase_reg <= 2'd0;
              end
            endcase
          end
        end
        S_ISSUE: begin
          cmd_data_reg  <= step_byte;
          cmd_rs_reg    <= step_is_char;
          cmd_start_reg <= 1'b1;
        end
        S_WAIT:  if (iCMD_DONE) cmd_start_reg <= 1'b0;
        S_DELAY: dly_cnt_reg <= dly_last ? '0 : dly_cnt_reg + CNT_W'(1);
        S_NEXT: begin
          if (last_step) frame_done_reg <= 1'b1;
          else           step_reg       <= step_reg + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign oCHAR_MSG   = char_msg_reg;
  assign oCHAR_POS   = char_pos_reg;
  assign oCMD_DATA   = cmd_data_reg;
  assign oCMD_RS     = cmd_rs_reg;
  assign oCMD_START  = cmd_start_reg;
  assign oBUSY       = busy_reg;
  assign oFRAME_DONE = frame_done_reg;

endmodule
